// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the RV32I core pipeline stages.
//   XLEN          - datapath width.
//   NOP_INSTR     - ADDI x0,x0,0. Injected by fetch on flush/halt and decoded
//                   as Nop by Control_Unit.
//   fetch_state_t - debugger run-control states of the fetch stage.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: debugger run-control FSM (RUN / HALTED / STEP) of the fetch stage.
// This block decides on each edge whether the fetch datapath issues, injects a
// NOP, or holds.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset.
//   stall         - downstream hazard stall.
//   br_taken      - redirect from execute. It flushes in every state.
//   halt_req      - debugger halt request. It is level-sampled and only acts in RUN.
//   resume_req    - debugger resume pulse.
//   step_req      - debugger single-step pulse.
//   pc_wr_req     - debugger pc write request. Tie it to 0 when the feature is absent.
//   issue_en      - datapath: register {pc, imem_rdata, 1} and advance pc.
//   inject_nop    - datapath: register {pc, NOP, 0}.
//   pc_wr_en      - datapath: load the debugger pc value.
//   halted        - registered. 1 while the core is not free-running (HALTED or STEP).
//   step_done     - registered. One-cycle pulse after the stepped issue.
// The current state is held in state_q.
module dbg_run_ctrl
    import core_pkg::*;
#(
    parameter logic START_HALTED = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic br_taken,
    input  logic halt_req,
    input  logic resume_req,
    input  logic step_req,
    input  logic pc_wr_req,
    output logic issue_en,
    output logic inject_nop,
    output logic pc_wr_en,
    output logic halted,
    output logic step_done
);

    localparam fetch_state_t RESET_STATE = START_HALTED ? HALTED : RUN;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         step_fire;

    always_comb begin
        state_d    = state_q;
        issue_en   = 1'b0;
        inject_nop = 1'b0;
        step_fire  = 1'b0;
        case (state_q)
            RUN: begin
                if (br_taken) begin
                    inject_nop = 1'b1;
                    if (halt_req) state_d = HALTED;
                end else if (halt_req) begin
                    inject_nop = 1'b1;
                    state_d    = HALTED;
                end else if (!stall) begin
                    issue_en = 1'b1;
                end
            end
            HALTED: begin
                // The debugger pulses are always accepted here, so that a
                // downstream stall cannot swallow them. Resume wins over step.
                inject_nop = 1'b1;
                if (resume_req)    state_d = RUN;
                else if (step_req) state_d = STEP;
            end
            STEP: begin
                // A redirect landing in STEP counts as the stepped instruction.
                if (br_taken) begin
                    inject_nop = 1'b1;
                    step_fire  = 1'b1;
                    state_d    = HALTED;
                end else if (!stall) begin
                    issue_en  = 1'b1;
                    step_fire = 1'b1;
                    state_d   = HALTED;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    assign pc_wr_en = pc_wr_req && (state_q == HALTED) && !br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            halted    <= START_HALTED;
            step_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted    <= (state_d != RUN);
            step_done <= step_fire;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 3-stage RV32I core.
// It holds the pc, addresses instruction memory, and registers
// {pc, instruction, valid} into IF/ID. It also handles redirect, stall,
// NOP flush and debugger run control. Run control lives in dbg_run_ctrl.
// Optional feature (macro FETCH_DBG_PC_WRITE_EN): adds dbg_pc_we/dbg_pc_wdata
// so that the debugger can rewrite pc while HALTED.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset.
//   imem_addr / imem_rdata      - instruction-memory address and combinational data.
//   stall                       - hold pc and IF/ID.
//   br_taken / br_target        - redirect. The target is word-aligned on load.
//   if_id_pc/instr/valid        - IF/ID pipeline register.
//   halt_req/resume_req/step_req - debugger run control.
//   halted, step_done           - registered debugger status.
//   dbg_pc                      - current pc.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR    = core_pkg::NOP_INSTR,
    parameter logic            START_HALTED = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    input  logic            halt_req,
    input  logic            resume_req,
    input  logic            step_req,
`ifdef FETCH_DBG_PC_WRITE_EN
    input  logic            dbg_pc_we,
    input  logic [XLEN-1:0] dbg_pc_wdata,
`endif
    output logic            halted,
    output logic            step_done,
    output logic [XLEN-1:0] dbg_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h3;

    logic [XLEN-1:0] pc;
    logic            issue_en;
    logic            inject_nop;
    logic            pc_wr_req;
    logic            pc_wr_en;
    logic [XLEN-1:0] pc_wr_data;

`ifdef FETCH_DBG_PC_WRITE_EN
    assign pc_wr_req  = dbg_pc_we;
    assign pc_wr_data = dbg_pc_wdata & ALIGN_MASK;
`else
    assign pc_wr_req  = 1'b0;
    assign pc_wr_data = '0;
`endif

    dbg_run_ctrl #(
        .START_HALTED (START_HALTED)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .halt_req   (halt_req),
        .resume_req (resume_req),
        .step_req   (step_req),
        .pc_wr_req  (pc_wr_req),
        .issue_en   (issue_en),
        .inject_nop (inject_nop),
        .pc_wr_en   (pc_wr_en),
        .halted     (halted),
        .step_done  (step_done)
    );

    assign imem_addr = pc & ALIGN_MASK;
    assign dbg_pc    = pc;

    // The redirect beats a debugger write. Increment wraps modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (br_taken) begin
            pc <= br_target & ALIGN_MASK;
        end else if (pc_wr_en) begin
            pc <= pc_wr_data;
        end else if (issue_en) begin
            pc <= pc + 32'd4;
        end
    end

    // When neither enable is set, the register is left unchanged (stall).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (inject_nop) begin
            if_id_pc    <= pc;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (issue_en) begin
            if_id_pc    <= pc;
            if_id_instr <= imem_rdata;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, br_taken;
    logic [31:0] br_target;
    logic [31:0] if_id_pc, if_id_instr;
    logic        if_id_valid;
    logic        halt_req, resume_req, step_req;
    logic        halted, step_done;
    logic [31:0] dbg_pc;
    logic        dbg_pc_we;
    logic [31:0] dbg_pc_wdata;

    // Second instance: leaves reset halted at a non-zero pc, with idle inputs.
    logic [31:0] h_imem_addr, h_if_id_pc, h_if_id_instr, h_dbg_pc;
    logic        h_if_id_valid, h_halted, h_step_done;

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word 0 is 0x00500093; the other words are address-tagged.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[19:0], 12'h000};
    endfunction
    assign imem_rdata = imem_word(imem_addr);

    fetch_stage u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .halt_req    (halt_req),
        .resume_req  (resume_req),
        .step_req    (step_req),
`ifdef FETCH_DBG_PC_WRITE_EN
        .dbg_pc_we   (dbg_pc_we),
        .dbg_pc_wdata(dbg_pc_wdata),
`endif
        .halted      (halted),
        .step_done   (step_done),
        .dbg_pc      (dbg_pc)
    );

    fetch_stage #(.RESET_PC(32'h0000_1000), .START_HALTED(1'b1)) u_dut_h (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (h_imem_addr),
        .imem_rdata  (imem_word(h_imem_addr)),
        .stall       (1'b0),
        .br_taken    (1'b0),
        .br_target   (32'h0),
        .if_id_pc    (h_if_id_pc),
        .if_id_instr (h_if_id_instr),
        .if_id_valid (h_if_id_valid),
        .halt_req    (1'b0),
        .resume_req  (1'b0),
        .step_req    (1'b0),
`ifdef FETCH_DBG_PC_WRITE_EN
        .dbg_pc_we   (1'b0),
        .dbg_pc_wdata(32'h0),
`endif
        .halted      (h_halted),
        .step_done   (h_step_done),
        .dbg_pc      (h_dbg_pc)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic        st, br;
        logic [31:0] tgt;
        logic        hq, rs, sp;
        logic [31:0] e_pc, e_ifpc, e_instr;
        logic        e_v, e_h, e_sd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, br, input logic [31:0] tgt,
                                input logic hq, rs, sp,
                                input logic [31:0] e_pc, e_ifpc, e_instr,
                                input logic e_v, e_h, e_sd);
        vec_t v;
        v.st = st; v.br = br; v.tgt = tgt; v.hq = hq; v.rs = rs; v.sp = sp;
        v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_instr = e_instr;
        v.e_v = e_v; v.e_h = e_h; v.e_sd = e_sd;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    // Each entry is packed as {pc, if_id_pc, if_id_instr, valid, halted, step_done}.
    logic [98:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [98:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".pc"},        dbg_pc,               e[98:67]);
        chk({tag, ".imem_addr"}, imem_addr,            e[98:67] & ~32'h3);
        chk({tag, ".if_id_pc"},  if_id_pc,             e[66:35]);
        chk({tag, ".instr"},     if_id_instr,          e[34:3]);
        chk({tag, ".valid"},     {31'b0, if_id_valid}, {31'b0, e[2]});
        chk({tag, ".halted"},    {31'b0, halted},      {31'b0, e[1]});
        chk({tag, ".step_done"}, {31'b0, step_done},   {31'b0, e[0]});
    endtask

    task automatic drive(input logic st, br, input logic [31:0] tgt, input logic hq, rs, sp);
        stall = st; br_taken = br; br_target = tgt;
        halt_req = hq; resume_req = rs; step_req = sp;
    endtask

    // ---------------- test ----------------
    initial begin
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 0);
        dbg_pc_we = 1'b0;
        dbg_pc_wdata = 32'h0;

        //            st br tgt           hq rs sp  pc            if_pc         instr                    v  h  sd
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0004, 32'h0000_0000, imem_word(32'h0),        1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0008, 32'h0000_0004, imem_word(32'h4),        1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0000_0008, 32'h0000_0004, imem_word(32'h4),        1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0000_0008, 32'h0000_0004, imem_word(32'h4),        1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0000_0008, 32'h0000_0004, imem_word(32'h4),        1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_000C, 32'h0000_0008, imem_word(32'h8),        1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h102,      0, 0, 0, 32'h0000_0100, 32'h0000_000C, NOP,                     0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h20,       0, 0, 0, 32'h0000_0020, 32'h0000_0100, NOP,                     0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0000_0020, 32'h0000_0020, NOP,                     0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0000_0020, 32'h0000_0020, NOP,                     0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0020, 32'h0000_0020, NOP,                     0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0024, 32'h0000_0020, imem_word(32'h20),       1, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0024, 32'h0000_0024, NOP,                     0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0024, 32'h0000_0024, NOP,                     0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0028, 32'h0000_0024, imem_word(32'h24),       1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0000_0028, 32'h0000_0028, NOP,                     0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0000_0028, 32'h0000_0028, NOP,                     0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_002C, 32'h0000_0028, imem_word(32'h28),       1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h40,       1, 0, 0, 32'h0000_0040, 32'h0000_002C, NOP,                     0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0040, 32'h0000_0040, NOP,                     0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0000_0040, 32'h0000_0040, NOP,                     0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h80,       0, 0, 0, 32'h0000_0080, 32'h0000_0040, NOP,                     0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0000_0080, 32'h0000_0080, NOP,                     0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0080, 32'h0000_0080, NOP,                     0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0084, 32'h0000_0080, imem_word(32'h80),       1, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFE,0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0084, NOP,                     0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, imem_word(32'hFFFF_FFFC),1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0004, 32'h0000_0000, imem_word(32'h0),        1, 0, 0));

        // Reset state before any clock edge.
        #12;
        chk("rst.pc",        dbg_pc,               32'h0);
        chk("rst.imem_addr", imem_addr,            32'h0);
        chk("rst.if_id_pc",  if_id_pc,             32'h0);
        chk("rst.instr",     if_id_instr,          NOP);
        chk("rst.valid",     {31'b0, if_id_valid}, 32'h0);
        chk("rst.halted",    {31'b0, halted},      32'h0);
        chk("rst.step_done", {31'b0, step_done},   32'h0);
        chk("rst_h.pc",      h_dbg_pc,             32'h0000_1000);
        chk("rst_h.halted",  {31'b0, h_halted},    32'h1);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].hq, vecs[i].rs, vecs[i].sp);
            exp_q.push_back({vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].e_instr,
                             vecs[i].e_v, vecs[i].e_h, vecs[i].e_sd});
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", i));
            @(negedge clk);
        end
        drive(0, 0, 32'h0, 0, 0, 0);

        // The START_HALTED instance must stay parked at its reset pc.
        chk("halt_inst.pc",     h_dbg_pc,                 32'h0000_1000);
        chk("halt_inst.halted", {31'b0, h_halted},        32'h1);
        chk("halt_inst.valid",  {31'b0, h_if_id_valid},   32'h0);
        chk("halt_inst.instr",  h_if_id_instr,            NOP);
        chk("halt_inst.sd",     {31'b0, h_step_done},     32'h0);

`ifdef FETCH_DBG_PC_WRITE_EN
        // Debugger pc write: taken when HALTED, beaten by a redirect, ignored in RUN.
        drive(0, 0, 32'h0, 1, 0, 0);
        @(posedge clk); #1; chk("dbgw.halt_pc", dbg_pc, 32'h0000_0004);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 0);
        dbg_pc_we = 1'b1; dbg_pc_wdata = 32'h0000_0203;
        @(posedge clk); #1; chk("dbgw.halted_write", dbg_pc, 32'h0000_0200);
        @(negedge clk);
        drive(0, 1, 32'h0000_0300, 0, 0, 0);
        @(posedge clk); #1; chk("dbgw.br_priority", dbg_pc, 32'h0000_0300);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 1, 0);
        dbg_pc_we = 1'b0;
        @(posedge clk); #1; chk("dbgw.resume_pc", dbg_pc, 32'h0000_0300);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 0);
        dbg_pc_we = 1'b1; dbg_pc_wdata = 32'h0000_0203;
        @(posedge clk); #1; chk("dbgw.run_ignored", dbg_pc, 32'h0000_0304);
        @(negedge clk);
        dbg_pc_we = 1'b0;
`endif

        // An asynchronous reset in mid-cycle acts without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.pc",       dbg_pc,               32'h0);
        chk("arst.instr",    if_id_instr,          NOP);
        chk("arst.valid",    {31'b0, if_id_valid}, 32'h0);
        chk("arst.if_id_pc", if_id_pc,             32'h0);
        chk("arst.halted",   {31'b0, halted},      32'h0);
        chk("arst_h.pc",     h_dbg_pc,             32'h0000_1000);
        @(negedge clk);
        rst_n = 1'b1;

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
